// File: rtl/prbs15_pattern_seq.sv
// prbs15_pattern_seq: fetches a 4-byte word from the byte serializer,
// shifts it out LSB-first n_repeat times, then free-runs PRBS-15.
module prbs15_pattern_seq #(
  parameter logic [14:0] SEED  = 15'h7FFF,
  parameter int          REP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [REP_W-1:0] n_repeat,
  input  logic [7:0]       ser_byte,
  output logic [1:0]       byte_num,
  output logic             ser_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             prbs_mode,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SHIFT,
    S_PRBS
  } state_t;

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [14:0] SEED_EFF =
    (SEED == 15'd0) ? 15'h0001 : SEED;

  function automatic logic [14:0] lfsr_step(
    input logic [14:0] v
  );
    return {v[13:0], v[14] ^ v[13]};
  endfunction

  state_t           state;
  state_t           state_d;
  logic [7:0]       shreg;
  logic [7:0]       shreg_d;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_cnt_d;
  logic [1:0]       byte_idx;
  logic [1:0]       byte_idx_d;
  logic [REP_W-1:0] pass_cnt;
  logic [REP_W-1:0] pass_cnt_d;
  logic [REP_W-1:0] pass_inc;
  logic [REP_W-1:0] rep;
  logic [REP_W-1:0] rep_d;
  logic [14:0]      lfsr;
  logic [14:0]      lfsr_d;

  logic [1:0]       byte_num_d;
  logic             ser_en_d;
  logic             bit_d;
  logic             valid_d;
  logic             prbs_d;
  logic             busy_d;

  assign pass_inc = pass_cnt + REP_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, datapath updates and next output values.
  // Outputs are computed from the next state so that the
  // registered copies line up with the state they describe.
  // shreg holds the bits still to be sent after bit_out.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    bit_cnt_d  = bit_cnt;
    byte_idx_d = byte_idx;
    pass_cnt_d = pass_cnt;
    rep_d      = rep;
    lfsr_d     = lfsr;
    bit_d      = 1'b0;

    if (stop) begin
      state_d    = S_IDLE;
      byte_idx_d = 2'd0;
      bit_cnt_d  = 3'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            byte_idx_d = 2'd0;
            pass_cnt_d = '0;
            rep_d      = n_repeat;
            if (n_repeat != '0) begin
              state_d = S_FETCH;
            end else begin
              state_d = S_PRBS;
            end
          end
        end
        S_FETCH: begin
          state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          bit_d     = ser_byte[0];
          shreg_d   = {1'b0, ser_byte[7:1]};
          bit_cnt_d = 3'd0;
          state_d   = S_SHIFT;
        end
        S_SHIFT: begin
          if (bit_cnt == 3'd7) begin
            if (byte_idx != 2'd3) begin
              byte_idx_d = byte_idx + 2'd1;
              state_d    = S_FETCH;
            end else begin
              byte_idx_d = 2'd0;
              pass_cnt_d = pass_inc;
              if (pass_inc == rep) begin
                state_d = S_PRBS;
              end else begin
                state_d = S_FETCH;
              end
            end
          end else begin
            bit_d     = shreg[0];
            shreg_d   = {1'b0, shreg[7:1]};
            bit_cnt_d = bit_cnt + 3'd1;
          end
        end
        S_PRBS: begin
          bit_d  = lfsr[14];
          lfsr_d = lfsr_step(lfsr);
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Entering PRBS: first bit comes straight from the seed,
    // the register then runs one step ahead of bit_out.
    if (state_d == S_PRBS && state != S_PRBS) begin
      bit_d  = SEED_EFF[14];
      lfsr_d = lfsr_step(SEED_EFF);
    end

    ser_en_d   = (state_d == S_FETCH);
    valid_d    = (state_d == S_SHIFT) ||
                 (state_d == S_PRBS);
    prbs_d     = (state_d == S_PRBS);
    busy_d     = (state_d != S_IDLE);
    byte_num_d = busy_d ? byte_idx_d : 2'd0;
    bit_d      = bit_d & valid_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= 8'd0;
      bit_cnt  <= 3'd0;
      byte_idx <= 2'd0;
      pass_cnt <= '0;
      rep      <= '0;
      lfsr     <= SEED;
    end else begin
      shreg    <= shreg_d;
      bit_cnt  <= bit_cnt_d;
      byte_idx <= byte_idx_d;
      pass_cnt <= pass_cnt_d;
      rep      <= rep_d;
      lfsr     <= lfsr_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_num  <= 2'd0;
      ser_en    <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      prbs_mode <= 1'b0;
      busy      <= 1'b0;
    end else begin
      byte_num  <= byte_num_d;
      ser_en    <= ser_en_d;
      bit_out   <= bit_d;
      bit_valid <= valid_d;
      prbs_mode <= prbs_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: doc/prbs15_pattern_seq.md
Name: prbs15_pattern_seq

Overview:
- Sequencer and bit serializer directly downstream of the byte serializer (Byte_Ser) in the PRBS-15 pattern path.
- Drives the byte serializer's `byte_num` and `enable` to fetch the four bytes of the pattern word in order, and shifts each byte out LSB-first on a 1-bit serial output.
- Repeats the 4-byte word `n_repeat` times, then switches permanently to a free-running PRBS-15 (x^15 + x^14 + 1) bit stream until stopped.

Parameters:
- SEED, 15'h7FFF, LFSR value loaded on entry to PRBS mode. A value of 0 is replaced by 15'h0001.
- REP_W, 8, width of `n_repeat` and of the pass counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a sequence when idle.
- stop  input  1  synchronous abort; returns the block to IDLE.
- n_repeat  input  REP_W  number of passes over the 4-byte word; sampled on accepted start.
- ser_byte  input  8  registered byte from the byte serializer.
- byte_num  output  2  byte select to the byte serializer.
- ser_en  output  1  enable to the byte serializer.
- bit_out  output  1  serial data.
- bit_valid  output  1  `bit_out` is meaningful this cycle.
- prbs_mode  output  1  high while emitting PRBS bits.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; `byte_num`, `ser_en`, `bit_out`, `bit_valid`, `prbs_mode`, `busy` all 0.
  - Shift register, bit_cnt, byte_idx and pass_cnt = 0; lfsr = SEED.
  - Reset mid-operation aborts immediately, with no partial completion.
- States: IDLE, FETCH, CAPTURE, SHIFT, PRBS.
- IDLE:
  - `start`=1 with `n_repeat`!=0 → FETCH; byte_idx=0, pass_cnt=0, `n_repeat` latched.
  - `start`=1 with `n_repeat`=0 → PRBS directly.
  - `start` is ignored outside IDLE.
- FETCH (1 cycle): `ser_en`=1, `byte_num`=byte_idx, `bit_valid`=0 → CAPTURE.
- CAPTURE (1 cycle): `ser_en`=0. The byte serializer's registered output is valid this cycle; `ser_byte` is loaded into the shift register, bit_cnt=0 → SHIFT. `bit_valid`=0.
- SHIFT (8 cycles):
  - `bit_valid`=1, `bit_out`=shreg[0]; shreg shifts right each cycle; bit_cnt increments.
  - On bit_cnt=7: if byte_idx<3, byte_idx++ → FETCH.
  - Otherwise byte_idx=0 and pass_cnt++. If pass_cnt+1 == latched `n_repeat` → PRBS, else → FETCH.
- `byte_num` holds byte_idx in all non-IDLE states and is 0 in IDLE.
- Timing:
  - Each byte costs 10 cycles (2 bubble cycles + 8 valid bits); each pass costs 40 cycles.
  - First valid bit appears 3 cycles after the start cycle (start at cycle 0 → FETCH at cycle 1, CAPTURE at cycle 2, first bit at cycle 3).
- PRBS:
  - On entry, lfsr=SEED (or 1 if SEED=0). `prbs_mode`=1 and `bit_valid`=1 every cycle.
  - `bit_out`=lfsr[14]; each cycle lfsr <= {lfsr[13:0], lfsr[14]^lfsr[13]}.
  - Stays in PRBS indefinitely, with period 32767 bits.
- `stop`=1 in any state → IDLE next cycle with all outputs 0. `stop` has priority over `start` in the same cycle (block stays IDLE).
- Registered outputs: all outputs are registered and change only on the clk edge, or asynchronously on reset.

Test Plan:
- Reset then idle: hold rst=0, then release with no start → all outputs 0; `busy`=0 for 20 cycles.
- Single pass: word bytes 0x01,0x80,0xA5,0xFF; start with `n_repeat`=1.
  - `ser_en` pulses at cycles 1, 11, 21, 31 with `byte_num`=0, 1, 2, 3.
  - Bit stream is 10000000, 00000001, 10100101, 11111111.
  - `prbs_mode`=1 at cycle 41.
- Repeat count: `n_repeat`=3 → 96 valid pattern bits, with the word repeated three times identically, then `prbs_mode` asserts at cycle 121.
- PRBS content: SEED=7FFF, `n_repeat`=0 → first 15 bits are 1, the 16th bit is 0; the sequence repeats after 32767 bits and is checked against a reference LFSR model.
- Abort:
  - `stop` asserted during SHIFT of byte 2 → next cycle IDLE, `bit_valid`=0.
  - A new start then restarts from byte 0 with pass_cnt=0.
  - Assert rst=0 in PRBS → outputs drop to 0 asynchronously.
- Start ignored and priority: a start pulse while busy has no effect on sequence timing; `start` and `stop` together in IDLE → remains IDLE.
